// File: rtl/rr_muxn_reg.sv
// rtl/rr_muxn_reg.sv - N-channel registered mux with round-robin or fixed-priority grant
module rr_muxn_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter bit RR    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  // The index width is derived by the integrator; a mismatch would silently
  // truncate channel numbers, so refuse to elaborate.
  if (SELW != $clog2(NCH)) begin : g_bad_selw
    $error("rr_muxn_reg: SELW must equal clog2(NCH)");
  end

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] cand;
  logic            found;
  logic            load;

  // Channel k positions after base, wrapping at NCH (NCH need not be a power of two).
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NCH) s = s - NCH;
    return SELW'(s);
  endfunction

  // The output stage can accept a word when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  // Arbitration: first valid channel scanning from ptr (RR) or from 0 (fixed).
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!found) begin
        cand = RR ? wrap_idx(ptr, k) : SELW'(k);
        if (in_valid[cand]) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
  end

  // Only the granted channel sees ready, and only when the stage can load.
  always_comb begin
    in_ready = '0;
    if (load && found && !rst) in_ready[grant] = 1'b1;
  end

  // Output stage and round-robin pointer; only the granted slice of in_data is read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant*WIDTH +: WIDTH];
        out_ch    <= grant;
        if (RR) ptr <= (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_muxn_reg.sv
// tb/tb_rr_muxn_reg.sv - directed self-checking bench for rr_muxn_reg
module tb_rr_muxn_reg;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_ready;

  logic [NCH-1:0]       rr_in_ready;
  logic                 rr_out_valid;
  logic [WIDTH-1:0]     rr_out_data;
  logic [SELW-1:0]      rr_out_ch;

  logic [NCH-1:0]       fp_in_ready;
  logic                 fp_out_valid;
  logic [WIDTH-1:0]     fp_out_data;
  logic [SELW-1:0]      fp_out_ch;

  int errors = 0;
  int checks = 0;

  rr_muxn_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .RR(1'b1)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_ch    (rr_out_ch),
    .out_ready (out_ready)
  );

  rr_muxn_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .RR(1'b0)) u_fp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_ch    (fp_out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    logic [NCH-1:0] exp_rdy;

    rst       = 1'b1;
    in_valid  = 4'hf;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();

    // Reset state, with requests pending during reset
    chk("rst_out_valid", 64'(rr_out_valid), 64'd0);
    chk("rst_out_data",  64'(rr_out_data),  64'd0);
    chk("rst_out_ch",    64'(rr_out_ch),    64'd0);
    chk("rst_in_ready",  64'(rr_in_ready),  64'd0);
    chk("rst_fp_ready",  64'(fp_in_ready),  64'd0);

    // Round-robin fairness from reset: all valid, ch i carries i
    for (int i = 0; i < NCH; i++) set_word(i, WIDTH'(i));
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_rdy = 4'b0001 << (i % 4);
      chk($sformatf("fair_in_ready_%0d", i), 64'(rr_in_ready), 64'(exp_rdy));
      chk($sformatf("fair_fp_ready_%0d", i), 64'(fp_in_ready), 64'h1);
      step();
      chk($sformatf("fair_out_ch_%0d", i),    64'(rr_out_ch),    64'(i % 4));
      chk($sformatf("fair_out_data_%0d", i),  64'(rr_out_data),  64'(i % 4));
      chk($sformatf("fair_out_valid_%0d", i), 64'(rr_out_valid), 64'd1);
    end

    // Asynchronous reset mid-stream clears the output stage immediately
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(rr_out_valid), 64'd0);
    chk("arst_out_data",  64'(rr_out_data),  64'd0);
    chk("arst_out_ch",    64'(rr_out_ch),    64'd0);
    chk("arst_in_ready",  64'(rr_in_ready),  64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("arst_first_ready", 64'(rr_in_ready), 64'h1);
    step();
    chk("arst_first_ch",    64'(rr_out_ch),    64'd0);
    chk("arst_first_valid", 64'(rr_out_valid), 64'd1);

    // Single channel ch2 (ptr currently 1)
    in_valid = 4'b0100;
    set_word(2, 32'hdeadbeef);
    #1;
    chk("single_in_ready", 64'(rr_in_ready), 64'h4);
    step();
    chk("single_out_valid", 64'(rr_out_valid), 64'd1);
    chk("single_out_data",  64'(rr_out_data),  64'hdeadbeef);
    chk("single_out_ch",    64'(rr_out_ch),    64'd2);
    // ptr is now 3: with all valid, ch3 would win
    in_valid = 4'hf;
    #1;
    chk("ptr3_probe", 64'(rr_in_ready), 64'h8);

    // Wrap: only ch3 valid, ptr wraps to 0, then drain with no request
    in_valid = 4'b1000;
    set_word(3, 32'h33330003);
    #1;
    chk("wrap_in_ready", 64'(rr_in_ready), 64'h8);
    step();
    chk("wrap_out_ch",   64'(rr_out_ch),   64'd3);
    chk("wrap_out_data", 64'(rr_out_data), 64'h33330003);
    in_valid = 4'b0000;
    step();
    chk("drain_out_valid", 64'(rr_out_valid), 64'd0);
    chk("drain_out_data",  64'(rr_out_data),  64'h33330003);
    chk("drain_out_ch",    64'(rr_out_ch),    64'd3);
    in_valid = 4'hf;
    #1;
    chk("ptr0_probe", 64'(rr_in_ready), 64'h1);

    // Backpressure: load beefdead from ch0, then stall three cycles
    in_valid = 4'b0001;
    set_word(0, 32'hbeefdead);
    set_word(1, 32'h11111111);
    #1;
    step();
    chk("bp_load_data", 64'(rr_out_data), 64'hbeefdead);
    chk("bp_load_ch",   64'(rr_out_ch),   64'd0);
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", i), 64'(rr_in_ready), 64'd0);
      step();
      chk($sformatf("bp_valid_%0d", i), 64'(rr_out_valid), 64'd1);
      chk($sformatf("bp_data_%0d", i),  64'(rr_out_data),  64'hbeefdead);
      chk($sformatf("bp_ch_%0d", i),    64'(rr_out_ch),    64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(rr_in_ready), 64'h2);
    step();
    chk("bp_release_ch",    64'(rr_out_ch),    64'd1);
    chk("bp_release_data",  64'(rr_out_data),  64'h11111111);
    chk("bp_release_valid", 64'(rr_out_valid), 64'd1);

    // Fixed priority vs round-robin: ch1 and ch3 valid for three cycles
    rst = 1'b1;
    in_valid = 4'b0000;
    step();
    rst = 1'b0;
    set_word(1, 32'ha1a1a1a1);
    set_word(3, 32'hc3c3c3c3);
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("fp_in_ready_%0d", i), 64'(fp_in_ready), 64'h2);
      step();
      chk($sformatf("fp_out_ch_%0d", i),   64'(fp_out_ch),   64'd1);
      chk($sformatf("fp_out_data_%0d", i), 64'(fp_out_data), 64'ha1a1a1a1);
      chk($sformatf("rr_alt_ch_%0d", i),   64'(rr_out_ch),   64'((i % 2 == 0) ? 1 : 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
